// File: rtl/lfsr_gen.sv
// Run-time configurable LFSR (Fibonacci or Galois) with period measurement,
// return-to-seed pulse, no-return detection and lock-up detection.
module lfsr_gen #(
   parameter  int unsigned N  = 8,
   localparam int unsigned CW = N + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_seed,
   input  logic [N-1:0]  seed_data,
   input  logic [N-1:0]  taps_in,
   input  logic          mode_in,
   input  logic          step,
   output logic [N-1:0]  lfsr_data,
   output logic          lfsr_done,
   output logic [CW-1:0] period_out,
   output logic          period_valid,
   output logic          no_return,
   output logic          lock_err
);

   localparam logic [CW-1:0] CNT_FULL = {1'b1, {N{1'b0}}};

   logic [N-1:0]  state_q, state_d;
   logic [N-1:0]  seed_q, seed_d;
   logic [N-1:0]  taps_q, taps_d;
   logic          mode_q, mode_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] period_q, period_d;
   logic          done_q, done_d;
   logic          pvalid_q, pvalid_d;
   logic          noret_q, noret_d;
   logic          lock_q, lock_d;

   logic [N-1:0]  fib_next_c;
   logic [N-1:0]  gal_next_c;
   logic [N-1:0]  next_c;
   logic [CW-1:0] count_inc_c;

   // Successor state for both topologies; mode selects which one is used.
   always_comb begin
      fib_next_c  = {state_q[N-2:0], ^(state_q & taps_q)};
      gal_next_c  = {state_q[N-2:0], 1'b0} ^ (state_q[N-1] ? taps_q : '0);
      next_c      = mode_q ? gal_next_c : fib_next_c;
      count_inc_c = count_q + CW'(1);
   end

   always_comb begin
      state_d  = state_q;
      seed_d   = seed_q;
      taps_d   = taps_q;
      mode_d   = mode_q;
      count_d  = count_q;
      period_d = period_q;
      done_d   = 1'b0;
      pvalid_d = pvalid_q;
      noret_d  = noret_q;
      lock_d   = lock_q;

      if (load_seed) begin
         state_d  = seed_data;
         seed_d   = seed_data;
         taps_d   = taps_in;
         mode_d   = mode_in;
         count_d  = '0;
         period_d = '0;
         pvalid_d = 1'b0;
         noret_d  = 1'b0;
         lock_d   = 1'b0;
      end else if (step) begin
         state_d = next_c;
         if (next_c == '0) begin
            lock_d = 1'b1;
         end
         // Measurement runs only until the first return or the no-return verdict.
         if (!pvalid_q && !noret_q) begin
            if (count_q != CNT_FULL) begin
               count_d = count_inc_c;
            end
            if (next_c == seed_q) begin
               done_d   = 1'b1;
               period_d = count_inc_c;
               pvalid_d = 1'b1;
            end else if (count_inc_c == CNT_FULL) begin
               noret_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= '0;
         seed_q   <= '0;
         taps_q   <= '0;
         mode_q   <= 1'b0;
         count_q  <= '0;
         period_q <= '0;
         done_q   <= 1'b0;
         pvalid_q <= 1'b0;
         noret_q  <= 1'b0;
         lock_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         seed_q   <= seed_d;
         taps_q   <= taps_d;
         mode_q   <= mode_d;
         count_q  <= count_d;
         period_q <= period_d;
         done_q   <= done_d;
         pvalid_q <= pvalid_d;
         noret_q  <= noret_d;
         lock_q   <= lock_d;
      end
   end

   assign lfsr_data    = state_q;
   assign lfsr_done    = done_q;
   assign period_out   = period_q;
   assign period_valid = pvalid_q;
   assign no_return    = noret_q;
   assign lock_err     = lock_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: vector table, directed corner sequences and randomized
// run against an arithmetic reference model (N=4), plus an N=8 period run.
module tb_lfsr_gen;

   logic clk, reset;

   logic       load4, mode4, step4;
   logic [3:0] seed4, taps4, data4;
   logic       done4, pv4, nr4, lk4;
   logic [4:0] per4;

   logic       load8, mode8, step8;
   logic [7:0] seed8, taps8, data8;
   logic       done8, pv8, nr8, lk8;
   logic [8:0] per8;

   int total = 0;
   int bad   = 0;

   lfsr_gen #(.N(4)) dut4 (
      .clk(clk), .reset(reset), .load_seed(load4), .seed_data(seed4),
      .taps_in(taps4), .mode_in(mode4), .step(step4), .lfsr_data(data4),
      .lfsr_done(done4), .period_out(per4), .period_valid(pv4),
      .no_return(nr4), .lock_err(lk4));

   lfsr_gen #(.N(8)) dut8 (
      .clk(clk), .reset(reset), .load_seed(load8), .seed_data(seed8),
      .taps_in(taps8), .mode_in(mode8), .step(step8), .lfsr_data(data8),
      .lfsr_done(done8), .period_out(per8), .period_valid(pv8),
      .no_return(nr8), .lock_err(lk8));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: N=4, plain integer arithmetic over the published rules.
   int m_state, m_seed, m_taps, m_mode, m_steps, m_per;
   bit m_done, m_pv, m_nr, m_lk;

   function automatic int succ(input int s, input int t, input int m);
      if (m != 0) return ((s * 2) % 16) ^ ((s >= 8) ? t : 0);
      return ((s * 2) % 16) + ($countones(s & t) % 2);
   endfunction

   task automatic model_clear();
      m_state = 0; m_seed = 0; m_taps = 0; m_mode = 0; m_steps = 0;
      m_per = 0; m_done = 0; m_pv = 0; m_nr = 0; m_lk = 0;
   endtask

   task automatic model_edge(input bit ld, input int sd, input int tp, input bit md, input bit st);
      int nx;
      m_done = 0;
      if (ld) begin
         m_state = sd; m_seed = sd; m_taps = tp; m_mode = md;
         m_steps = 0; m_per = 0; m_pv = 0; m_nr = 0; m_lk = 0;
      end else if (st) begin
         nx = succ(m_state, m_taps, m_mode);
         m_state = nx;
         if (nx == 0) m_lk = 1;
         if (!m_pv && !m_nr) begin
            m_steps++;
            if (nx == m_seed) begin
               m_done = 1; m_pv = 1; m_per = m_steps;
            end else if (m_steps >= 16) begin
               m_nr = 1;
            end
         end
      end
   endtask

   // Drive at negedge, clock once, sample at the next negedge.
   task automatic cyc(input bit ld, input logic [3:0] sd, input logic [3:0] tp, input bit md, input bit st);
      load4 = ld; seed4 = sd; taps4 = tp; mode4 = md; step4 = st;
      @(posedge clk);
      model_edge(ld, int'(sd), int'(tp), md, st);
      @(negedge clk);
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".data"},   32'(data4), 32'(m_state));
      chk({tag, ".done"},   32'(done4), 32'(m_done));
      chk({tag, ".period"}, 32'(per4),  32'(m_per));
      chk({tag, ".pvalid"}, 32'(pv4),   32'(m_pv));
      chk({tag, ".noret"},  32'(nr4),   32'(m_nr));
      chk({tag, ".lock"},   32'(lk4),   32'(m_lk));
   endtask

   typedef struct {
      logic       ld;
      logic [3:0] seed;
      logic [3:0] taps;
      logic       mode;
      logic       st;
      logic [3:0] e_data;
      logic       e_done;
      logic       e_pv;
      logic [4:0] e_per;
      logic       e_lk;
   } vec_t;

   vec_t tbl[15];

   function automatic vec_t mk(input logic ld, input logic [3:0] sd, input logic [3:0] tp,
                               input logic md, input logic st, input logic [3:0] ed,
                               input logic edn, input logic epv, input logic [4:0] ep,
                               input logic elk);
      vec_t v;
      v.ld = ld; v.seed = sd; v.taps = tp; v.mode = md; v.st = st;
      v.e_data = ed; v.e_done = edn; v.e_pv = epv; v.e_per = ep; v.e_lk = elk;
      return v;
   endfunction

   initial begin
      int pulses, steps, held, nsteps;
      bit got;

      tbl[0]  = mk(1, 4'b0001, 4'b1100, 0, 0, 4'b0001, 0, 0, 0, 0);
      tbl[1]  = mk(0, 0, 0, 0, 1, 4'b0010, 0, 0, 0, 0);
      tbl[2]  = mk(0, 0, 0, 0, 1, 4'b0100, 0, 0, 0, 0);
      tbl[3]  = mk(0, 0, 0, 0, 1, 4'b1001, 0, 0, 0, 0);
      tbl[4]  = mk(0, 0, 0, 0, 1, 4'b0011, 0, 0, 0, 0);
      tbl[5]  = mk(1, 4'b0001, 4'b0011, 1, 1, 4'b0001, 0, 0, 0, 0);
      tbl[6]  = mk(0, 4'b1111, 4'b1111, 0, 1, 4'b0010, 0, 0, 0, 0);
      tbl[7]  = mk(0, 0, 0, 0, 1, 4'b0100, 0, 0, 0, 0);
      tbl[8]  = mk(0, 0, 0, 0, 1, 4'b1000, 0, 0, 0, 0);
      tbl[9]  = mk(0, 0, 0, 0, 1, 4'b0011, 0, 0, 0, 0);
      tbl[10] = mk(0, 0, 0, 0, 1, 4'b0110, 0, 0, 0, 0);
      tbl[11] = mk(0, 0, 0, 0, 0, 4'b0110, 0, 0, 0, 0);
      tbl[12] = mk(1, 4'b0000, 4'b1011, 0, 0, 4'b0000, 0, 0, 0, 0);
      tbl[13] = mk(0, 0, 0, 0, 1, 4'b0000, 1, 1, 5'd1, 1);
      tbl[14] = mk(0, 0, 0, 0, 1, 4'b0000, 0, 1, 5'd1, 1);

      reset = 1'b0;
      load4 = 0; seed4 = 0; taps4 = 0; mode4 = 0; step4 = 0;
      load8 = 0; seed8 = 0; taps8 = 0; mode8 = 0; step8 = 0;
      model_clear();
      @(negedge clk);
      @(negedge clk);
      chk_model("reset");
      reset = 1'b1;
      @(negedge clk);

      // Vector table
      foreach (tbl[i]) begin
         cyc(tbl[i].ld, tbl[i].seed, tbl[i].taps, tbl[i].mode, tbl[i].st);
         chk($sformatf("vec%0d.data", i),   32'(data4), 32'(tbl[i].e_data));
         chk($sformatf("vec%0d.done", i),   32'(done4), 32'(tbl[i].e_done));
         chk($sformatf("vec%0d.pvalid", i), 32'(pv4),   32'(tbl[i].e_pv));
         chk($sformatf("vec%0d.period", i), 32'(per4),  32'(tbl[i].e_per));
         chk($sformatf("vec%0d.lock", i),   32'(lk4),   32'(tbl[i].e_lk));
      end

      // Full Fibonacci run with a 3-cycle step gap mid-run
      cyc(1, 4'b0001, 4'b1100, 0, 0);
      pulses = 0; steps = 0;
      for (int i = 0; i < 5; i++) begin cyc(0, 0, 0, 0, 1); steps++; end
      held = int'(data4);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 0, 0);
         chk("gap.data", 32'(data4), 32'(held));
      end
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         cyc(0, 0, 0, 0, 1); steps++;
         if (done4) begin got = 1; pulses++; end
      end
      chk("fib.done_seen", 32'(got), 32'd1);
      chk("fib.steps", 32'(steps), 32'd15);
      chk("fib.data", 32'(data4), 32'd1);
      chk("fib.period", 32'(per4), 32'd15);
      chk("fib.pvalid", 32'(pv4), 32'd1);
      for (int i = 0; i < 20; i++) begin
         cyc(0, 0, 0, 0, 1);
         if (done4) pulses++;
      end
      chk("fib.pulses", 32'(pulses), 32'd1);
      chk("fib.period_kept", 32'(per4), 32'd15);

      // Non-invertible polynomial: no return within 2^N steps
      cyc(1, 4'b1000, 4'b0100, 0, 0);
      for (int i = 0; i < 15; i++) cyc(0, 0, 0, 0, 1);
      chk("noret.before", 32'(nr4), 32'd0);
      cyc(0, 0, 0, 0, 1);
      chk("noret.after", 32'(nr4), 32'd1);
      chk("noret.pvalid", 32'(pv4), 32'd0);
      chk("noret.lock", 32'(lk4), 32'd1);

      // Randomized run against the model, with one mid-run reset
      for (int i = 0; i < 600; i++) begin
         if (i == 300) begin
            reset = 1'b0;
            #1;
            model_clear();
            chk_model("midreset");
            @(negedge clk);
            reset = 1'b1;
         end
         cyc(($urandom_range(0, 24) == 0), 4'($urandom), 4'($urandom),
             1'($urandom), ($urandom_range(0, 3) != 0));
         chk_model($sformatf("rnd%0d", i));
      end

      // N=8 maximal-length Fibonacci
      load8 = 1; seed8 = 8'h01; taps8 = 8'b1011_1000; mode8 = 0; step8 = 0;
      @(negedge clk);
      load8 = 0; step8 = 1;
      got = 0; nsteps = 0;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         nsteps++;
         if (done8) got = 1;
      end
      step8 = 0;
      chk("n8.done_seen", 32'(got), 32'd1);
      chk("n8.steps", 32'(nsteps), 32'd255);
      chk("n8.period", 32'(per8), 32'd255);
      chk("n8.pvalid", 32'(pv8), 32'd1);
      chk("n8.noret", 32'(nr8), 32'd0);
      chk("n8.lock", 32'(lk8), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
